// File: rtl/fft4_pkg.sv
// Shared definitions for the streaming 4-point FFT/IFFT: FSM state encoding and output width helper.
package fft4_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ST1  = 2'd1,
        ST2  = 2'd2,
        EMIT = 2'd3
    } state_t;

    function automatic int ow(input int dw);
        return dw + 2;
    endfunction

endpackage

// File: rtl/fft4_butterfly.sv
// Combinational radix-2 complex butterfly: (a, b) -> (a+b, a-b), one bit of growth.
module fft4_butterfly #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a_re,
    input  logic signed [W-1:0] a_im,
    input  logic signed [W-1:0] b_re,
    input  logic signed [W-1:0] b_im,
    output logic signed [W:0]   sum_re,
    output logic signed [W:0]   sum_im,
    output logic signed [W:0]   dif_re,
    output logic signed [W:0]   dif_im
);

    assign sum_re = $signed({a_re[W-1], a_re}) + $signed({b_re[W-1], b_re});
    assign sum_im = $signed({a_im[W-1], a_im}) + $signed({b_im[W-1], b_im});
    assign dif_re = $signed({a_re[W-1], a_re}) - $signed({b_re[W-1], b_re});
    assign dif_im = $signed({a_im[W-1], a_im}) - $signed({b_im[W-1], b_im});

endmodule

// File: rtl/fft4_stream.sv
// Streaming 4-point radix-2 FFT/IFFT with valid/ready on both sides; IFFT output scaled by 1/4.
// Build option FFT4_ROUND_EN: IFFT scaling rounds half up instead of flooring.
//
// state | meaning
// LOAD  | accept 4 samples, latch mode with sample 0
// ST1   | register first butterfly stage (DW+1 bits)
// ST2   | register bins (OW bits), apply IFFT scaling
// EMIT  | present bins 0..3 to the sink
module fft4_stream
    import fft4_pkg::*;
#(
    parameter  int DW = 8,
    localparam int OW = ow(DW)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    input  logic                 in_inverse,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_re,
    output logic signed [OW-1:0] out_im,
    output logic [1:0]           out_idx,
    output logic                 out_last,
    output logic                 out_inverse
);

    localparam int SW = DW + 1;

    localparam logic [1:0] S_LOAD = LOAD;
    localparam logic [1:0] S_ST1  = ST1;
    localparam logic [1:0] S_ST2  = ST2;
    localparam logic [1:0] S_EMIT = EMIT;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_x_t;

    typedef struct packed {
        logic signed [SW-1:0] re;
        logic signed [SW-1:0] im;
    } cplx_s_t;

    typedef struct packed {
        logic signed [OW-1:0] re;
        logic signed [OW-1:0] im;
    } cplx_o_t;

    logic [1:0] state;
    logic [1:0] cnt;
    logic [1:0] idx;
    logic       mode;
    logic       out_inv;

    cplx_x_t x  [4];
    cplx_s_t s0, s1, s2, s3;
    cplx_o_t xo [4];

    cplx_s_t s0_n, s1_n, s2_n, s3_n;
    cplx_o_t x0_n, x2_n;

    fft4_butterfly #(.W(DW)) u_bf_02 (
        .a_re(x[0].re), .a_im(x[0].im), .b_re(x[2].re), .b_im(x[2].im),
        .sum_re(s0_n.re), .sum_im(s0_n.im), .dif_re(s1_n.re), .dif_im(s1_n.im)
    );

    fft4_butterfly #(.W(DW)) u_bf_13 (
        .a_re(x[1].re), .a_im(x[1].im), .b_re(x[3].re), .b_im(x[3].im),
        .sum_re(s2_n.re), .sum_im(s2_n.im), .dif_re(s3_n.re), .dif_im(s3_n.im)
    );

    fft4_butterfly #(.W(SW)) u_bf_x02 (
        .a_re(s0.re), .a_im(s0.im), .b_re(s2.re), .b_im(s2.im),
        .sum_re(x0_n.re), .sum_im(x0_n.im), .dif_re(x2_n.re), .dif_im(x2_n.im)
    );

    // The +/-j twiddle terms swap re/im, so they are built inline at OW bits.
    logic signed [OW-1:0] s1_re_w, s1_im_w, s3_re_w, s3_im_w;
    logic signed [OW-1:0] p_re, p_im, m_re, m_im;

    assign s1_re_w = {s1.re[SW-1], s1.re};
    assign s1_im_w = {s1.im[SW-1], s1.im};
    assign s3_re_w = {s3.re[SW-1], s3.re};
    assign s3_im_w = {s3.im[SW-1], s3.im};

    assign p_re = s1_re_w + s3_im_w;
    assign p_im = s1_im_w - s3_re_w;
    assign m_re = s1_re_w - s3_im_w;
    assign m_im = s1_im_w + s3_re_w;

    function automatic logic signed [OW-1:0] scale(input logic signed [OW-1:0] v);
`ifdef FFT4_ROUND_EN
        logic signed [OW:0] t;
        t = $signed({v[OW-1], v}) + $signed((OW+1)'(2));
        return OW'(t >>> 2);
`else
        return v >>> 2;
`endif
    endfunction

    function automatic cplx_o_t bin_out(input logic inv, input cplx_o_t v);
        cplx_o_t r;
        r = v;
        if (inv) begin
            r.re = scale(v.re);
            r.im = scale(v.im);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_LOAD;
            cnt     <= 2'd0;
            idx     <= 2'd0;
            mode    <= 1'b0;
            out_inv <= 1'b0;
            s0      <= '0;
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            for (int i = 0; i < 4; i++) begin
                x[i]  <= '0;
                xo[i] <= '0;
            end
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        x[cnt] <= {in_re, in_im};
                        if (cnt == 2'd0) mode <= in_inverse;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) state <= S_ST1;
                    end
                end
                S_ST1: begin
                    s0    <= s0_n;
                    s1    <= s1_n;
                    s2    <= s2_n;
                    s3    <= s3_n;
                    state <= S_ST2;
                end
                S_ST2: begin
                    xo[0]   <= bin_out(mode, x0_n);
                    xo[2]   <= bin_out(mode, x2_n);
                    xo[1]   <= bin_out(mode, mode ? {m_re, m_im} : {p_re, p_im});
                    xo[3]   <= bin_out(mode, mode ? {p_re, p_im} : {m_re, m_im});
                    out_inv <= mode;
                    idx     <= 2'd0;
                    state   <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) state <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    assign in_ready    = (state == S_LOAD);
    assign out_valid   = (state == S_EMIT);
    assign out_idx     = idx;
    assign out_last    = out_valid && (idx == 2'd3);
    assign out_inverse = out_inv;
    assign out_re      = xo[idx].re;
    assign out_im      = xo[idx].im;

endmodule

// File: tb/tb_fft4_stream.sv
// Scoreboard bench for fft4_stream: directed frames push expected bins, a monitor checks transfers.
// Expected IFFT scaling follows the FFT4_ROUND_EN build option.
module tb_fft4_stream;

    localparam int DW = 8;
    localparam int OW = DW + 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic                 in_inverse;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_re;
    logic signed [OW-1:0] out_im;
    logic [1:0]           out_idx;
    logic                 out_last;
    logic                 out_inverse;

    fft4_stream #(.DW(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_inverse(in_inverse),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
        .out_last(out_last), .out_inverse(out_inverse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [OW-1:0] re;
        logic signed [OW-1:0] im;
        logic [1:0]           idx;
        logic                 last;
        logic                 inv;
    } bin_t;

    bin_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   acc_cnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
    endtask

    // Monitor: checks every bin transfer against the scoreboard and held bins under back-pressure.
    initial begin : monitor
        bin_t act;
        bin_t held;
        bin_t e;
        logic held_v;
        logic seen;
        held_v = 1'b0;
        seen   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v  = 1'b0;
                seen    = 1'b0;
                acc_cnt = 0;
                continue;
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                if (acc_cnt % 4 == 0) acc_cyc = cyc;
            end
            if (out_valid) begin
                act = {out_re, out_im, out_idx, out_last, out_inverse};
                chk("no_overlap_in_ready", 64'(in_ready), 64'd0);
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", 64'(cyc - acc_cyc), 64'd3);
                end
                if (!out_ready) begin
                    if (held_v) chk("hold_stable", 64'(act), 64'(held));
                    held   = act;
                    held_v = 1'b1;
                end else begin
                    held_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_bin actual=%0h required=none", act);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("bin%0d", e.idx), 64'(act), 64'(e));
                    end
                end
            end else begin
                seen   = 1'b0;
                held_v = 1'b0;
            end
        end
    end

    task automatic issue(input int xr[4], input int xi[4], input logic inv,
                         input int er[4], input int ei[4]);
        bin_t b;
        int   t;
        for (int k = 0; k < 4; k++) begin
            b.re   = OW'(er[k]);
            b.im   = OW'(ei[k]);
            b.idx  = 2'(k);
            b.last = (k == 3);
            b.inv  = inv;
            exp_q.push_back(b);
        end
        for (int n = 0; n < 4; n++) begin
            in_valid   = 1'b1;
            in_re      = DW'(xr[n]);
            in_im      = DW'(xi[n]);
            // Only sample 0 carries the mode; later samples deliberately disagree.
            in_inverse = (n == 0) ? inv : ~inv;
            t = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                t++;
                if (t > 50) begin
                    timeout_fail("accept");
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 60) begin
                timeout_fail("drain");
                exp_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int xr[4], input int xi[4], input logic inv,
                         input int er[4], input int ei[4]);
        issue(xr, xi, inv, er, ei);
        drain();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int t;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_re      = '0;
        in_im      = '0;
        in_inverse = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_inverse", 64'(out_inverse), 64'd0);
        chk("rst_out_data", 64'({out_re, out_im}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        frame('{1, 0, 0, 0}, '{0, 0, 0, 0}, 1'b0, '{1, 1, 1, 1}, '{0, 0, 0, 0});
        frame('{0, 1, 0, 0}, '{0, 0, 0, 0}, 1'b0, '{1, 0, -1, 0}, '{0, -1, 0, 1});
        frame('{1, 1, 1, 1}, '{0, 0, 0, 0}, 1'b0, '{4, 0, 0, 0}, '{0, 0, 0, 0});
        frame('{4, 0, 0, 0}, '{0, 0, 0, 0}, 1'b1, '{1, 1, 1, 1}, '{0, 0, 0, 0});
        frame('{-128, -128, -128, -128}, '{-128, -128, -128, -128}, 1'b0,
              '{-512, 0, 0, 0}, '{-512, 0, 0, 0});
        frame('{1, 3, 0, -2}, '{2, -1, 5, 1}, 1'b0, '{2, -1, 0, 3}, '{7, -8, 7, 2});
`ifdef FFT4_ROUND_EN
        frame('{2, 0, 0, 0}, '{0, 0, 0, 0}, 1'b1, '{1, 1, 1, 1}, '{0, 0, 0, 0});
        frame('{-2, 0, 0, 0}, '{0, 0, 0, 0}, 1'b1, '{0, 0, 0, 0}, '{0, 0, 0, 0});
        frame('{1, 3, 0, -2}, '{2, -1, 5, 1}, 1'b1, '{1, 1, 0, 0}, '{2, 1, 2, -2});
`else
        frame('{2, 0, 0, 0}, '{0, 0, 0, 0}, 1'b1, '{0, 0, 0, 0}, '{0, 0, 0, 0});
        frame('{-2, 0, 0, 0}, '{0, 0, 0, 0}, 1'b1, '{-1, -1, -1, -1}, '{0, 0, 0, 0});
        frame('{1, 3, 0, -2}, '{2, -1, 5, 1}, 1'b1, '{0, 0, 0, -1}, '{1, 0, 1, -2});
`endif

        // Back-pressure: sink stalls for 5 cycles while bin 1 is presented.
        issue('{1, 3, 0, -2}, '{2, -1, 5, 1}, 1'b0, '{2, -1, 0, 3}, '{7, -8, 7, 2});
        t = 0;
        while (!(out_valid && out_idx == 2'd1)) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 40) begin
                timeout_fail("wait_bin1");
                break;
            end
        end
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset while bin 2 is presented aborts the frame.
        issue('{0, 1, 0, 0}, '{0, 0, 0, 0}, 1'b0, '{1, 0, -1, 0}, '{0, -1, 0, 1});
        t = 0;
        while (!(out_valid && out_idx == 2'd2)) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 40) begin
                timeout_fail("wait_bin2");
                break;
            end
        end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_idx", 64'(out_idx), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        frame('{1, 3, 0, -2}, '{2, -1, 5, 1}, 1'b0, '{2, -1, 0, 3}, '{7, -8, 7, 2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
